mem_port_rv32i: RTL and testbench

Single-port memory front end for the RV32I pipeline. It arbitrates instruction fetch and memory-stage data transactions onto one shared, variable-latency memory bus. It drives the `instruction_ready` and `data_ready` signals that the hazard unit consumes to stall, enable and flush pipeline stages. It sits between the fetch/memory stages and the external memory controller.

---
 rtl/mem_port_pkg.sv | 20 ++
 rtl/mem_port_rv32i_fetch_buffer.sv | 46 ++++
 rtl/mem_port_rv32i.sv | 136 +++++++++++++
 tb/tb_mem_port_rv32i.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// mem_port_pkg
//   Shared types and constants for the RV32I single-port memory front end.
//   - mem_state_t : arbiter/bus FSM states
//   - DEF_ADDR_W / DEF_DATA_W : default byte-address and word widths
//   - BE_ALL : full-word byte-enable pattern for the default word width
package mem_port_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUS_I  = 2'd1,
    BUS_D  = 2'd2,
    RESP_D = 2'd3
  } mem_state_t;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic [DEF_DATA_W/8-1:0] BE_ALL = '1;

endpackage

// File: rtl/mem_port_rv32i_fetch_buffer.sv
// fetch_buffer
//   One-entry instruction buffer: data word, address tag and valid bit.
//   hit is asserted combinationally while the stored tag equals lookup_addr.
// Ports:
//   clk         in  : clock, all updates on rising edge
//   clr         in  : synchronous clear (valid, tag and data to 0)
//   wr          in  : write enable, loads wr_tag/wr_data and sets valid
//   wr_tag      in  : address the stored word belongs to
//   wr_data     in  : fetched word
//   lookup_addr in  : current PC to compare against the tag
//   rd_data     out : stored word
//   hit         out : valid && tag == lookup_addr
module fetch_buffer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              hit
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_tag;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (wr) begin
      r_valid <= 1'b1;
      r_tag   <= wr_tag;
      r_data  <= wr_data;
    end
  end

  assign rd_data = r_data;
  assign hit     = r_valid && (r_tag == lookup_addr);

endmodule

// File: rtl/mem_port_rv32i.sv
// mem_port_rv32i
//   Arbitrates instruction fetch and memory-stage loads/stores onto one
//   variable-latency memory bus. Data requests win over fetch. Fetched words
//   land in a one-entry tagged buffer; instruction_ready is a tag hit.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   fetch_addr               : current PC
//   instruction, instruction_ready : buffered word and its hit flag
//   mem_transaction, data_we, data_addr, data_be, data_wdata : data request
//   read_data, data_ready    : load result and one-cycle completion pulse
//   mem_req, mem_we, mem_addr, mem_be, mem_wdata : registered bus request
//   mem_ack, mem_rdata       : bus completion and read data
module mem_port_rv32i
  import mem_port_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   fetch_addr,
  output logic [DATA_W-1:0]   instruction,
  output logic                instruction_ready,
  input  logic                mem_transaction,
  input  logic                data_we,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W/8-1:0] data_be,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   read_data,
  output logic                data_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  mem_state_t          r_state;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W/8-1:0] r_mem_be;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_read_data;
  logic                r_data_ready;

  logic                w_buf_wr;
  logic                w_buf_hit;
  logic [DATA_W-1:0]   w_buf_data;

  // The fetch completes even if the PC moved meanwhile; the buffer is tagged
  // with the issued address so a stale word simply never hits.
  assign w_buf_wr = (r_state == BUS_I) && mem_ack;

  fetch_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fetch_buffer (
    .clk         (clk),
    .clr         (rst),
    .wr          (w_buf_wr),
    .wr_tag      (r_mem_addr),
    .wr_data     (mem_rdata),
    .lookup_addr (fetch_addr),
    .rd_data     (w_buf_data),
    .hit         (w_buf_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_be     <= '0;
      r_mem_wdata  <= '0;
      r_read_data  <= '0;
      r_data_ready <= 1'b0;
    end else begin
      r_data_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          // Data is the older instruction, so it takes the bus first.
          if (mem_transaction) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= data_we;
            r_mem_addr  <= data_addr;
            r_mem_be    <= data_we ? data_be : '1;
            r_mem_wdata <= data_wdata;
            r_state     <= BUS_D;
          end else if (!w_buf_hit) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= fetch_addr;
            r_mem_be    <= '1;
            r_mem_wdata <= '0;
            r_state     <= BUS_I;
          end
        end
        BUS_I: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
          end
        end
        BUS_D: begin
          if (mem_ack) begin
            r_mem_req    <= 1'b0;
            r_read_data  <= mem_rdata;
            r_data_ready <= 1'b1;
            r_state      <= RESP_D;
          end
        end
        RESP_D: begin
          // No arbitration here: the memory stage still shows the finished
          // operation until the hazard unit advances it on data_ready.
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign instruction       = w_buf_data;
  assign instruction_ready = w_buf_hit;
  assign read_data         = r_read_data;
  assign data_ready        = r_data_ready;
  assign mem_req           = r_mem_req;
  assign mem_we            = r_mem_we;
  assign mem_addr          = r_mem_addr;
  assign mem_be            = r_mem_be;
  assign mem_wdata         = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_rv32i.sv
module tb_mem_port_rv32i;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_addr;
  logic [31:0] instruction;
  logic        instruction_ready;
  logic        mem_transaction;
  logic        data_we;
  logic [31:0] data_addr;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic [31:0] read_data;
  logic        data_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_chk = 0;
  int n_err = 0;

  mem_port_rv32i dut (
    .clk               (clk),
    .rst               (rst),
    .fetch_addr        (fetch_addr),
    .instruction       (instruction),
    .instruction_ready (instruction_ready),
    .mem_transaction   (mem_transaction),
    .data_we           (data_we),
    .data_addr         (data_addr),
    .data_be           (data_be),
    .data_wdata        (data_wdata),
    .read_data         (read_data),
    .data_ready        (data_ready),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_be            (mem_be),
    .mem_wdata         (mem_wdata),
    .mem_ack           (mem_ack),
    .mem_rdata         (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, mem_req}, 32'd1);
  endtask

  // Called while mem_req is high; acks after d cycles, returns one cycle
  // after the ack cycle.
  task automatic serve(input int d, input logic [31:0] v);
    repeat (d) tick();
    mem_ack   = 1'b1;
    mem_rdata = v;
    tick();
    mem_ack   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fetch_addr = 32'h100; mem_transaction = 1'b0; data_we = 1'b0;
    data_addr = '0; data_be = '0; data_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk("rst_req",   {31'd0, mem_req}, 32'd0);
    chk("rst_dr",    {31'd0, data_ready}, 32'd0);
    chk("rst_irdy",  {31'd0, instruction_ready}, 32'd0);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_rdata", read_data, 32'd0);
    chk("rst_addr",  mem_addr, 32'd0);
    rst = 1'b0;

    // Single fetch, ack 3 cycles after mem_req
    wait_req("f1_req");
    chk("f1_addr", mem_addr, 32'h100);
    chk("f1_we",   {31'd0, mem_we}, 32'd0);
    chk("f1_be",   {28'd0, mem_be}, 32'hF);
    tick(); tick();
    chk("f1_hold", {31'd0, mem_req}, 32'd1);
    serve(1, 32'h0050_0093);
    chk("f1_irdy",  {31'd0, instruction_ready}, 32'd1);
    chk("f1_instr", instruction, 32'h0050_0093);
    chk("f1_reqlo", {31'd0, mem_req}, 32'd0);
    tick(); tick();
    chk("f1_stay",  {31'd0, instruction_ready}, 32'd1);
    chk("f1_noreq", {31'd0, mem_req}, 32'd0);
    fetch_addr = 32'h104; #1;
    chk("f1_drop",  {31'd0, instruction_ready}, 32'd0);
    tick();
    chk("f2_addr", mem_addr, 32'h104);
    serve(0, 32'h0000_0013);
    chk("f2_irdy", {31'd0, instruction_ready}, 32'd1);

    // Priority: load and fetch requested in the same IDLE cycle
    fetch_addr = 32'h108; mem_transaction = 1'b1; data_we = 1'b0; data_addr = 32'h2000;
    tick();
    chk("pr_req",  {31'd0, mem_req}, 32'd1);
    chk("pr_addr", mem_addr, 32'h2000);
    chk("pr_we",   {31'd0, mem_we}, 32'd0);
    chk("pr_be",   {28'd0, mem_be}, 32'hF);
    serve(1, 32'hCAFE_F00D);
    chk("pr_dr",    {31'd0, data_ready}, 32'd1);
    chk("pr_rdata", read_data, 32'hCAFE_F00D);
    mem_transaction = 1'b0;
    tick();
    chk("pr_dr_lo",  {31'd0, data_ready}, 32'd0);
    chk("pr_req_lo", {31'd0, mem_req}, 32'd0);
    tick();
    chk("pr_freq",  {31'd0, mem_req}, 32'd1);
    chk("pr_faddr", mem_addr, 32'h108);
    serve(0, 32'h0000_0011);
    chk("pr_firdy", {31'd0, instruction_ready}, 32'd1);

    // Store
    mem_transaction = 1'b1; data_we = 1'b1; data_be = 4'b0011;
    data_wdata = 32'hDEAD_BEEF; data_addr = 32'h3000;
    tick();
    chk("st_we",    {31'd0, mem_we}, 32'd1);
    chk("st_addr",  mem_addr, 32'h3000);
    chk("st_be",    {28'd0, mem_be}, 32'h3);
    chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    serve(2, 32'h0);
    chk("st_dr", {31'd0, data_ready}, 32'd1);
    mem_transaction = 1'b0; data_we = 1'b0;
    tick();
    chk("st_dr_lo", {31'd0, data_ready}, 32'd0);
    tick();
    chk("st_norepeat", {31'd0, mem_req}, 32'd0);

    // Redirect during an outstanding fetch
    fetch_addr = 32'h200; #1;
    chk("rd_irdy0", {31'd0, instruction_ready}, 32'd0);
    tick();
    chk("rd_addr0", mem_addr, 32'h200);
    tick();
    fetch_addr = 32'h300;
    serve(0, 32'h0000_AAAA);
    chk("rd_stale", {31'd0, instruction_ready}, 32'd0);
    fetch_addr = 32'h200; #1;
    chk("rd_tag",   {31'd0, instruction_ready}, 32'd1);
    chk("rd_word",  instruction, 32'h0000_AAAA);
    fetch_addr = 32'h300; #1;
    tick();
    chk("rd_addr1", mem_addr, 32'h300);
    serve(0, 32'h0000_BBBB);
    chk("rd_irdy1", {31'd0, instruction_ready}, 32'd1);
    chk("rd_instr", instruction, 32'h0000_BBBB);

    // Zero-wait load then fetch; request seen at t
    mem_transaction = 1'b1; data_addr = 32'h2004; fetch_addr = 32'h304;
    tick();
    chk("zw_req", {31'd0, mem_req}, 32'd1);
    serve(0, 32'h1234_5678);
    chk("zw_dr",    {31'd0, data_ready}, 32'd1);
    chk("zw_rdata", read_data, 32'h1234_5678);
    mem_transaction = 1'b0;
    tick();
    chk("zw_idle", {31'd0, mem_req}, 32'd0);
    tick();
    chk("zw_freq",  {31'd0, mem_req}, 32'd1);
    chk("zw_faddr", mem_addr, 32'h304);
    serve(0, 32'h0000_0033);
    chk("zw_irdy", {31'd0, instruction_ready}, 32'd1);

    // Reset during BUS_D, then a late ack
    mem_transaction = 1'b1; data_addr = 32'h4000;
    tick();
    chk("rs_busd", mem_addr, 32'h4000);
    rst = 1'b1; mem_transaction = 1'b0;
    tick(); tick();
    chk("rs_req",   {31'd0, mem_req}, 32'd0);
    chk("rs_we",    {31'd0, mem_we}, 32'd0);
    chk("rs_addr",  mem_addr, 32'd0);
    chk("rs_be",    {28'd0, mem_be}, 32'd0);
    chk("rs_rdata", read_data, 32'd0);
    chk("rs_irdy",  {31'd0, instruction_ready}, 32'd0);
    chk("rs_instr", instruction, 32'd0);
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_ack = 1'b0;
    chk("rs_late_dr", {31'd0, data_ready}, 32'd0);
    chk("rs_fetch",   mem_addr, 32'h304);
    tick();
    chk("rs_late_dr2", {31'd0, data_ready}, 32'd0);
    serve(1, 32'h0000_0077);
    chk("rs_irdy2",  {31'd0, instruction_ready}, 32'd1);
    chk("rs_instr2", instruction, 32'h0000_0077);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
